// File: rtl/alu_seq.sv
// Registered ALU with START/BUSY/DONE handshake and an optional iterative shift-add multiplier.
// Define ALU_MUL_EN to compile in the multiplier (OP=10); otherwise OP=10 reports ILLEGAL.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] ALUOut,
  output logic             ZERODETECT,
  output logic             OVF,
  output logic             ILLEGAL
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRA  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

  logic [WIDTH-1:0] out_reg, out_next;
  logic             zero_reg, zero_next;
  logic             ovf_reg, ovf_next;
  logic             ill_reg, ill_next;
  logic             done_reg, done_next;

  // Single-cycle datapath; the multiplier opcode falls into the illegal default here
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SW-1:0]    shamt;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    sum     = A + B;
    diff    = A - B;
    shamt   = B[SW-1:0];
    case (OP)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL:  alu_res = A << shamt;
      OP_SRA:  alu_res = $signed(A) >>> shamt;
      OP_OR:   alu_res = A | B;
      OP_AND:  alu_res = A & B;
      OP_XOR:  alu_res = A ^ B;
      OP_SRL:  alu_res = A >> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] acc_sum;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= S_IDLE;
      count_reg  <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    out_next    = out_reg;
    zero_next   = zero_reg;
    ovf_next    = ovf_reg;
    ill_next    = ill_reg;
    done_next   = 1'b0;
    acc_sum     = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    case (state_reg)
      S_IDLE: begin
        if (START) begin
          if (OP == OP_MUL) begin
            mcand_next  = A;
            mplier_next = B;
            acc_next    = '0;
            count_next  = CW'(WIDTH);
            state_next  = S_MUL;
          end else begin
            out_next  = alu_res;
            zero_next = (alu_res == '0);
            ovf_next  = alu_ovf;
            ill_next  = alu_ill;
            done_next = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_next    = acc_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        count_next  = count_reg - 1'b1;
        // Final iteration retires straight into the result register
        if (count_reg == CW'(1)) begin
          out_next   = acc_sum;
          zero_next  = (acc_sum == '0);
          ovf_next   = 1'b0;
          ill_next   = 1'b0;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign BUSY = (state_reg == S_MUL);
`else
  always_comb begin
    out_next  = out_reg;
    zero_next = zero_reg;
    ovf_next  = ovf_reg;
    ill_next  = ill_reg;
    done_next = 1'b0;
    if (START) begin
      out_next  = alu_res;
      zero_next = (alu_res == '0);
      ovf_next  = alu_ovf;
      ill_next  = alu_ill;
      done_next = 1'b1;
    end
  end

  assign BUSY = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_reg  <= '0;
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      ill_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      out_reg  <= out_next;
      zero_reg <= zero_next;
      ovf_reg  <= ovf_next;
      ill_reg  <= ill_next;
      done_reg <= done_next;
    end
  end

  assign ALUOut     = out_reg;
  assign ZERODETECT = zero_reg;
  assign OVF        = ovf_reg;
  assign ILLEGAL    = ill_reg;
  assign DONE       = done_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal checks plus random traffic against a behavioural model.
// Follows ALU_MUL_EN the same way as the design.
module tb_alu_seq;
  localparam int WIDTH = 16;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             START = 1'b0;
  logic [3:0]       OP = 4'd0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             BUSY, DONE, ZERODETECT, OVF, ILLEGAL;
  logic [WIDTH-1:0] ALUOut;

  int n_checks = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .ALUOut(ALUOut), .ZERODETECT(ZERODETECT),
    .OVF(OVF), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference semantics using plain integer arithmetic on signed/unsigned values
  task automatic model_op(input int op, input longint a, input longint b,
                          output longint r, output bit ov, output bit il);
    longint mask, sa, sb, s, smax, smin;
    int sh;
    mask = (longint'(1) << WIDTH) - 1;
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    smin = -(longint'(1) << (WIDTH - 1));
    sa = (a > smax) ? a - (longint'(1) << WIDTH) : a;
    sb = (b > smax) ? b - (longint'(1) << WIDTH) : b;
    sh = int'(b % WIDTH);
    r = 0; ov = 1'b0; il = 1'b0;
    case (op)
      0: begin s = sa + sb; r = (a + b) & mask; ov = (s > smax) || (s < smin); end
      1: begin s = sa - sb; r = (a - b) & mask; ov = (s > smax) || (s < smin); end
      2: r = (a << sh) & mask;
      3: r = (sa >>> sh) & mask;
      4: r = a | b;
      5: r = a & b;
      6: r = a ^ b;
      7: r = a >> sh;
      8: r = (sa < sb) ? 1 : 0;
      9: r = (a < b) ? 1 : 0;
      default: il = 1'b1;
    endcase
  endtask

  longint m_out = 0;
  bit     m_zero = 0, m_ovf = 0, m_ill = 0, m_done = 0;
  int     m_left = 0;
  longint m_mulres = 0;

  always @(posedge CLK or negedge RST_N) begin
    longint r;
    bit ov, il;
    if (!RST_N) begin
      m_out = 0; m_zero = 0; m_ovf = 0; m_ill = 0; m_done = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_out = m_mulres; m_zero = (m_out == 0); m_ovf = 0; m_ill = 0; m_done = 1;
        end
      end else if (START) begin
        if (OP == 4'd10 && MUL_EN) begin
          m_left = WIDTH;
          m_mulres = (longint'(A) * longint'(B)) & ((longint'(1) << WIDTH) - 1);
        end else begin
          model_op(int'(OP), longint'(A), longint'(B), r, ov, il);
          m_out = r; m_zero = (r == 0); m_ovf = ov; m_ill = il; m_done = 1;
        end
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    check("cyc_busy", BUSY, m_left > 0);
    check("cyc_done", DONE, m_done);
    check("cyc_out", ALUOut, m_out);
    check("cyc_zero", ZERODETECT, m_zero);
    check("cyc_ovf", OVF, m_ovf);
    check("cyc_ill", ILLEGAL, m_ill);
  end

  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge CLK);
    OP = op; A = a; B = b; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic [15:0] out, input bit z, input bit ov, input bit il);
    check({name, "_done"}, DONE, 1'b1);
    check({name, "_out"}, ALUOut, out);
    check({name, "_zero"}, ZERODETECT, z);
    check({name, "_ovf"}, OVF, ov);
    check({name, "_ill"}, ILLEGAL, il);
  endtask

  task automatic expect_reset_outputs(input string name);
    check({name, "_out"}, ALUOut, 16'h0);
    check({name, "_done"}, DONE, 1'b0);
    check({name, "_busy"}, BUSY, 1'b0);
    check({name, "_zero"}, ZERODETECT, 1'b0);
    check({name, "_ovf"}, OVF, 1'b0);
    check({name, "_ill"}, ILLEGAL, 1'b0);
  endtask

  initial begin
    int busy_cycles, done_at;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    expect_reset_outputs("reset");
    RST_N = 1'b1;

    do_op(4'd0, 16'd5, 16'd10);        expect_res("add_5_10", 16'd15, 0, 0, 0);
    @(negedge CLK);                    check("add_done_low", DONE, 1'b0);
    do_op(4'd1, 16'd1, 16'd1);         expect_res("sub_zero", 16'h0000, 1, 0, 0);
    do_op(4'd0, 16'h7FFF, 16'h0001);   expect_res("add_ovf", 16'h8000, 0, 1, 0);
    do_op(4'd1, 16'h8000, 16'h0001);   expect_res("sub_ovf", 16'h7FFF, 0, 1, 0);
    do_op(4'd3, 16'hFFF4, 16'd3);      expect_res("sra", 16'hFFFE, 0, 0, 0);
    do_op(4'd7, 16'hFFF4, 16'd3);      expect_res("srl", 16'h1FFE, 0, 0, 0);
    do_op(4'd2, 16'hFFFD, 16'h0012);   expect_res("sll", 16'hFFF4, 0, 0, 0);
    do_op(4'd8, 16'hFFFF, 16'h0001);   expect_res("slt", 16'h0001, 0, 0, 0);
    do_op(4'd9, 16'hFFFF, 16'h0001);   expect_res("sltu", 16'h0000, 1, 0, 0);
    do_op(4'd15, 16'h1234, 16'h5678);  expect_res("op15", 16'h0000, 1, 0, 1);

    if (MUL_EN) begin
      @(negedge CLK);
      OP = 4'd10; A = 16'hFFFD; B = 16'd7; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      busy_cycles = 0; done_at = -1;
      for (int i = 0; i <= 40; i++) begin
        if (BUSY) busy_cycles++;
        if (DONE) begin done_at = i; break; end
        if (i == 5) begin OP = 4'd0; A = 16'd1; B = 16'd2; START = 1'b1; end
        else START = 1'b0;
        @(negedge CLK);
      end
      check("mul_latency", done_at, 16);
      check("mul_busy_cycles", busy_cycles, 16);
      expect_res("mul", 16'hFFEB, 0, 0, 0);
      check("mul_busy_clear", BUSY, 1'b0);
      OP = 4'd0; A = 16'd3; B = 16'd4; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      expect_res("add_after_mul", 16'd7, 0, 0, 0);

      do_op(4'd10, 16'h1234, 16'h0F0F);
      repeat (4) @(negedge CLK);
      check("mul_abort_busy", BUSY, 1'b1);
    end else begin
      do_op(4'd10, 16'h1234, 16'h5678);
      expect_res("op10_nomul", 16'h0000, 1, 0, 1);
      check("op10_nomul_busy", BUSY, 1'b0);
      do_op(4'd0, 16'd3, 16'd4);
      expect_res("add_pre_reset", 16'd7, 0, 0, 0);
    end

    #1 RST_N = 1'b0;
    #1 expect_reset_outputs("async_reset");
    repeat (2) @(negedge CLK);
    expect_reset_outputs("reset_hold");
    RST_N = 1'b1;
    do_op(4'd5, 16'h00F0, 16'h0FF0);   expect_res("and_after_reset", 16'h00F0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      START = ($urandom_range(0, 3) != 0);
      OP = ($urandom_range(0, 5) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0: A = 16'h7FFF;
        1: A = 16'h8000;
        2: A = 16'hFFFF;
        default: A = 16'($urandom);
      endcase
      B = ($urandom_range(0, 5) == 0) ? 16'h0001 : 16'($urandom);
    end
    @(negedge CLK);
    START = 1'b0;
    repeat (WIDTH + 3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
